// File: rtl/latmon_pkg.sv
// Shared constants for the latency monitor: readback map, statistic
// initial values, histogram sizing and the histogram bin helper.
package latmon_pkg;

    // Readback address map
    localparam logic [3:0] RB_LAST      = 4'd0;
    localparam logic [3:0] RB_MIN       = 4'd1;
    localparam logic [3:0] RB_MAX       = 4'd2;
    localparam logic [3:0] RB_SUM       = 4'd3;
    localparam logic [3:0] RB_COUNT     = 4'd4;
    localparam logic [3:0] RB_MINMAX    = 4'd5;
    localparam logic [3:0] RB_HIST_BASE = 4'd8;

    // Value returned for unmapped addresses
    localparam logic [63:0] RB_BAD = 64'h0BADC0DE0BADC0DE;

    // min_lat starts at all-ones so the first sample always replaces it
    localparam logic [31:0] MIN_INIT = 32'hFFFF_FFFF;

    localparam int HIST_BINS = 8;

    // Skid payload is {tlast, tuser[127:0], tdata[31:0]}
    localparam int SKID_W = 161;

    // Clamp a shifted latency into the last histogram bin
    function automatic logic [2:0] hist_bin(input logic [31:0] shifted);
        return (shifted > 32'd7) ? 3'd7 : shifted[2:0];
    endfunction

endpackage

// File: rtl/latmon_skid.sv
// Two-entry AXI stream skid buffer. A beat accepted on one edge is
// presented on the output from the next cycle. s_ready is a flop holding
// "buffer will not be full", so the input never sees a combinational
// path from m_ready.
// Handshake: a transfer happens on an edge where valid and ready are both
// high; valid never waits on ready, and payload is held while valid & !ready.
module latmon_skid
    import latmon_pkg::*;
#(
    parameter int W = SKID_W
) (
    input  logic         ce_clk,
    input  logic         reset,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   fill;
    logic [1:0]   fill_next;
    logic         s_fire;
    logic         m_fire;

    assign s_fire  = s_valid & s_ready;
    assign m_fire  = m_valid & m_ready;
    assign m_valid = (fill != 2'd0);
    assign m_data  = rd_ptr ? mem1 : mem0;

    // Occupancy after this cycle's transfers
    always_comb begin
        fill_next = fill + {1'b0, s_fire} - {1'b0, m_fire};
    end

    // Pointers, occupancy and the registered ready flag
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset) begin
            fill    <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            fill    <= fill_next;
            s_ready <= (fill_next != 2'd2);
            if (s_fire) wr_ptr <= ~wr_ptr;
            if (m_fire) rd_ptr <= ~rd_ptr;
        end
    end

    // Storage; the slot being read is never written while occupied
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset) begin
            mem0 <= '0;
            mem1 <= '0;
        end else if (s_fire) begin
            if (wr_ptr) mem1 <= s_data;
            else        mem0 <= s_data;
        end
    end

endmodule

// File: rtl/latency_monitor.sv
// Latency monitor: passes the stamped AXI stream through a 2-entry skid
// buffer and, on each packet's first beat, measures timer - stamp and keeps
// last/min/max/sum/count statistics for registered host readback.
// Optional per-latency histogram enabled by defining LATMON_HIST_EN.
module latency_monitor
    import latmon_pkg::*;
#(
    parameter int TS_LSB    = 32,
    parameter int SUM_WIDTH = 48,
    parameter int BIN_SHIFT = 4
) (
    input  logic          ce_clk,
    input  logic          reset,
    input  logic [63:0]   timer,
    input  logic          clear,
    input  logic [31:0]   s_axis_tdata,
    input  logic          s_axis_tlast,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [127:0]  s_axis_tuser,
    output logic [31:0]   m_axis_tdata,
    output logic          m_axis_tlast,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [127:0]  m_axis_tuser,
    input  logic [3:0]    rb_addr,
    output logic [63:0]   rb_data,
    output logic          sample_stb
);

    logic [SKID_W-1:0]    skid_out;
    logic                 s_fire;
    logic                 sof;
    logic                 sample;
    logic [31:0]          lat;

    logic [31:0]          last_lat, min_lat, max_lat, count;
    logic [SUM_WIDTH-1:0] sum;
    logic [31:0]          base_last, base_min, base_max, base_count;
    logic [SUM_WIDTH-1:0] base_sum;
    logic [31:0]          last_next, min_next, max_next, count_next;
    logic [SUM_WIDTH-1:0] sum_next;
    logic [SUM_WIDTH:0]   sum_wide;
    logic [63:0]          rb_next;
    logic                 unused_bits;

    latmon_skid #(.W(SKID_W)) u_skid (
        .ce_clk  (ce_clk),
        .reset   (reset),
        .s_data  ({s_axis_tlast, s_axis_tuser, s_axis_tdata}),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (skid_out),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = skid_out;

    assign s_fire = s_axis_tvalid & s_axis_tready;
    assign sample = s_fire & sof;
    // Unsigned subtraction makes a timer wrap between stamp and arrival harmless
    assign lat    = timer[31:0] - s_axis_tuser[TS_LSB +: 32];

    // Start-of-frame flag: the beat after a tlast (or after reset) is a first beat
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset)      sof <= 1'b1;
        else if (s_fire) sof <= s_axis_tlast;
    end

    // Next statistics: clear restores the base, then a sample folds into it
    always_comb begin
        base_last  = clear ? 32'd0    : last_lat;
        base_min   = clear ? MIN_INIT : min_lat;
        base_max   = clear ? 32'd0    : max_lat;
        base_sum   = clear ? '0       : sum;
        base_count = clear ? 32'd0    : count;
        last_next  = base_last;
        min_next   = base_min;
        max_next   = base_max;
        sum_next   = base_sum;
        count_next = base_count;
        sum_wide   = {1'b0, base_sum} + (SUM_WIDTH+1)'(lat);
        if (sample) begin
            last_next  = lat;
            min_next   = (lat < base_min) ? lat : base_min;
            max_next   = (lat > base_max) ? lat : base_max;
            sum_next   = sum_wide[SUM_WIDTH] ? '1 : sum_wide[SUM_WIDTH-1:0];
            count_next = (base_count == 32'hFFFF_FFFF) ? base_count : base_count + 32'd1;
        end
    end

    // Statistics registers and the sample strobe
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset) begin
            last_lat   <= 32'd0;
            min_lat    <= MIN_INIT;
            max_lat    <= 32'd0;
            sum        <= '0;
            count      <= 32'd0;
            sample_stb <= 1'b0;
        end else begin
            last_lat   <= last_next;
            min_lat    <= min_next;
            max_lat    <= max_next;
            sum        <= sum_next;
            count      <= count_next;
            sample_stb <= sample;
        end
    end

`ifdef LATMON_HIST_EN
    logic [15:0] hist [HIST_BINS];
    logic [2:0]  bin;

    assign bin = hist_bin(lat >> BIN_SHIFT);

    // Saturating histogram counters; a sample alongside clear leaves 1 in its bin
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HIST_BINS; i++) hist[i] <= 16'd0;
        end else begin
            for (int i = 0; i < HIST_BINS; i++) begin
                if (sample && bin == 3'(i))
                    hist[i] <= clear ? 16'd1 :
                               ((hist[i] == 16'hFFFF) ? hist[i] : hist[i] + 16'd1);
                else if (clear)
                    hist[i] <= 16'd0;
            end
        end
    end

    assign unused_bits = ^timer[63:32];
`else
    assign unused_bits = ^{timer[63:32], 32'(BIN_SHIFT)};
`endif

    // Readback decode of the current (pre-update) statistics
    always_comb begin
        rb_next = RB_BAD;
        case (rb_addr)
            RB_LAST:   rb_next = {32'd0, last_lat};
            RB_MIN:    rb_next = {32'd0, min_lat};
            RB_MAX:    rb_next = {32'd0, max_lat};
            RB_SUM:    rb_next = 64'(sum);
            RB_COUNT:  rb_next = {32'd0, count};
            RB_MINMAX: rb_next = {min_lat, max_lat};
            default:   rb_next = RB_BAD;
        endcase
`ifdef LATMON_HIST_EN
        if (rb_addr >= RB_HIST_BASE) rb_next = {48'd0, hist[rb_addr[2:0]]};
`endif
    end

    // Registered readback port
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset) rb_data <= 64'd0;
        else        rb_data <= rb_next;
    end

endmodule

// File: tb/tb_latency_monitor.sv
// Self-checking bench for latency_monitor. Stimulus drives on the falling
// edge; a monitor samples 1 ns after the falling edge and pops expected
// beats and samples from scoreboard queues. Define LATMON_HIST_EN to cover
// the histogram build.
module tb_latency_monitor;

    localparam logic [63:0] BAD = 64'h0BADC0DE0BADC0DE;

    logic          ce_clk = 1'b0;
    logic          reset;
    logic [63:0]   timer;
    logic          clear;
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [127:0]  s_axis_tuser;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [127:0]  m_axis_tuser;
    logic [3:0]    rb_addr;
    logic [63:0]   rb_data;
    logic          sample_stb;

    int            tests = 0;
    int            fails = 0;
    logic [160:0]  exp_q[$];
    logic [31:0]   lat_q[$];
    logic          tb_sof;
    int            n_in = 0;
    int            n_out = 0;
    logic          chk_ready = 1'b0;
    logic          rand_ready = 1'b0;
    logic          ready_level = 1'b1;
    int            n_last;

    latency_monitor dut (
        .ce_clk        (ce_clk),
        .reset         (reset),
        .timer         (timer),
        .clear         (clear),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .rb_addr       (rb_addr),
        .rb_data       (rb_data),
        .sample_stb    (sample_stb)
    );

    // Clock
    always #5 ce_clk = ~ce_clk;

    // Output ready driver: random or held level
    always @(negedge ce_clk) begin
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on output transfers and sample strobes
    always begin
        @(negedge ce_clk);
        #1;
        if (reset !== 1'b1) begin
            exp_q.delete();
            lat_q.delete();
            n_in  = 0;
            n_out = 0;
        end else begin
            if (chk_ready && (n_in - n_out) < 2)
                check64("tready_free", {63'd0, s_axis_tready}, 64'd1);
            if (n_in - n_out > 2)
                check64("occupancy", 64'(n_in - n_out), 64'd2);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             {m_axis_tlast, m_axis_tuser, m_axis_tdata});
                end else begin
                    check64("beat_lo", 64'({m_axis_tlast, m_axis_tuser[31:0], m_axis_tdata}),
                            64'({exp_q[0][160], exp_q[0][63:0]}));
                    check64("beat_hi", m_axis_tuser[127:64], exp_q[0][159:96]);
                    void'(exp_q.pop_front());
                end
                n_out++;
            end
            if (s_axis_tvalid && s_axis_tready) n_in++;
            if (sample_stb) begin
                tests++;
                if (lat_q.size() == 0) begin
                    fails++;
                    $display("FAIL sample_stb: got pulse expected none");
                end else begin
                    void'(lat_q.pop_front());
                end
            end
        end
    end

    // Drive one beat and hold it until accepted; called and returns at negedge
    task automatic send_beat(input logic [31:0] data, input logic last,
                             input logic [31:0] stamp, input logic [31:0] tmr,
                             input logic do_clear);
        int guard;
        logic [127:0] user;
        user          = {32'hC0DE_0000, data, stamp, ~data};
        s_axis_tdata  = data;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        timer         = {32'h1234_5678, tmr};
        s_axis_tvalid = 1'b1;
        guard = 0;
        while (!s_axis_tready && guard < 200) begin
            @(negedge ce_clk);
            guard++;
        end
        if (!s_axis_tready) begin
            check64("accept_timeout", 64'd0, 64'd1);
            s_axis_tvalid = 1'b0;
            return;
        end
        clear = do_clear;
        exp_q.push_back({last, user, data});
        if (tb_sof) lat_q.push_back(tmr - stamp);
        tb_sof = last;
        @(negedge ce_clk);
        clear         = 1'b0;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge ce_clk);
        clear = 1'b0;
    endtask

    task automatic read_rb(input logic [3:0] addr, input logic [63:0] exp, input string name);
        rb_addr = addr;
        @(negedge ce_clk);
        check64(name, rb_data, exp);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge ce_clk);
            g++;
        end
        if (exp_q.size() != 0) check64("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge ce_clk);
    endtask

    // Directed vector tables
    logic [31:0] t2_stamp [3] = '{32'd1000, 32'd2000, 32'd3000};
    logic [31:0] t2_tmr   [3] = '{32'd1005, 32'd2050, 32'd3020};
    logic [31:0] h_stamp  [3] = '{32'd10, 32'd20, 32'd100};
    logic [31:0] h_tmr    [3] = '{32'd13, 32'd37, 32'd600};

    // Main sequence
    initial begin
        reset         = 1'b0;
        timer         = 64'd0;
        clear         = 1'b0;
        s_axis_tdata  = 32'd0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 128'd0;
        rb_addr       = 4'd0;
        tb_sof        = 1'b1;
        repeat (3) @(negedge ce_clk);

        // Reset state
        check64("rst_tready", {63'd0, s_axis_tready}, 64'd0);
        check64("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check64("rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
        check64("rst_rb", rb_data, 64'd0);
        check64("rst_stb", {63'd0, sample_stb}, 64'd0);
        reset = 1'b1;
        @(negedge ce_clk);
        check64("tready_after_rst", {63'd0, s_axis_tready}, 64'd1);
        read_rb(4'd1, 64'hFFFF_FFFF, "rst_min");

        // 4-beat packet, stamp 100, first-beat timer 130
        send_beat(32'h0000_0011, 1'b0, 32'd100, 32'd130, 1'b0);
        check64("first_out_valid", {63'd0, m_axis_tvalid}, 64'd1);
        check64("first_out_data", {32'd0, m_axis_tdata}, 64'h11);
        send_beat(32'h0000_0022, 1'b0, 32'd100, 32'd140, 1'b0);
        send_beat(32'h0000_0033, 1'b0, 32'd100, 32'd150, 1'b0);
        send_beat(32'h0000_0044, 1'b1, 32'd100, 32'd160, 1'b0);
        drain();
        read_rb(4'd0, 64'd30, "t1_last");
        read_rb(4'd1, 64'd30, "t1_min");
        read_rb(4'd2, 64'd30, "t1_max");
        read_rb(4'd3, 64'd30, "t1_sum");
        read_rb(4'd4, 64'd1, "t1_count");

        // Clear, then single-beat packets with latencies 5, 50, 20
        pulse_clear();
        read_rb(4'd1, 64'hFFFF_FFFF, "clr_min");
        read_rb(4'd4, 64'd0, "clr_count");
        read_rb(4'd3, 64'd0, "clr_sum");
        for (int i = 0; i < 3; i++)
            send_beat(32'h100 + 32'(i), 1'b1, t2_stamp[i], t2_tmr[i], 1'b0);
        drain();
        read_rb(4'd1, 64'd5, "t2_min");
        read_rb(4'd2, 64'd50, "t2_max");
        read_rb(4'd3, 64'd75, "t2_sum");
        read_rb(4'd4, 64'd3, "t2_count");
        read_rb(4'd5, {32'd5, 32'd50}, "t2_minmax");
        read_rb(4'd0, 64'd20, "t2_last");

        // Timer wrap between stamp and arrival
        pulse_clear();
        send_beat(32'h200, 1'b1, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0);
        drain();
        read_rb(4'd0, 64'd32, "wrap_last");

        // Random output ready over 1000 back-to-back beats
        pulse_clear();
        n_last     = 0;
        chk_ready  = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic lst;
            lst = ($urandom_range(0, 3) == 0) || (i == 999);
            if (lst) n_last++;
            send_beat($urandom, lst, $urandom, $urandom, 1'b0);
        end
        rand_ready = 1'b0;
        ready_level = 1'b1;
        drain();
        chk_ready = 1'b0;
        read_rb(4'd4, 64'(n_last), "rand_count");

        // Clear in the same cycle as a sample of latency 7
        send_beat(32'h300, 1'b1, 32'd200, 32'd207, 1'b1);
        drain();
        read_rb(4'd0, 64'd7, "clrs_last");
        read_rb(4'd1, 64'd7, "clrs_min");
        read_rb(4'd2, 64'd7, "clrs_max");
        read_rb(4'd3, 64'd7, "clrs_sum");
        read_rb(4'd4, 64'd1, "clrs_count");

        // Reset mid-packet with the buffer holding beats
        ready_level = 1'b0;
        @(negedge ce_clk);
        send_beat(32'h400, 1'b0, 32'd0, 32'd3, 1'b0);
        send_beat(32'h401, 1'b0, 32'd0, 32'd4, 1'b0);
        check64("pre_rst_valid", {63'd0, m_axis_tvalid}, 64'd1);
        reset = 1'b0;
        #2;
        check64("mid_rst_valid", {63'd0, m_axis_tvalid}, 64'd0);
        check64("mid_rst_tready", {63'd0, s_axis_tready}, 64'd0);
        check64("mid_rst_rb", rb_data, 64'd0);
        tb_sof = 1'b1;
        @(negedge ce_clk);
        reset = 1'b1;
        ready_level = 1'b1;
        @(negedge ce_clk);
        send_beat(32'h500, 1'b0, 32'd1000, 32'd1009, 1'b0);
        send_beat(32'h501, 1'b1, 32'd1000, 32'd1010, 1'b0);
        drain();
        read_rb(4'd0, 64'd9, "post_rst_last");
        read_rb(4'd4, 64'd1, "post_rst_count");

        // Latencies 3, 17, 500 for the histogram
        pulse_clear();
        for (int i = 0; i < 3; i++)
            send_beat(32'h600 + 32'(i), 1'b1, h_stamp[i], h_tmr[i], 1'b0);
        drain();
        read_rb(4'd1, 64'd3, "h_min");
        read_rb(4'd2, 64'd500, "h_max");
        read_rb(4'd4, 64'd3, "h_count");
`ifdef LATMON_HIST_EN
        read_rb(4'd8, 64'd1, "hist_bin0");
        read_rb(4'd9, 64'd1, "hist_bin1");
        read_rb(4'd10, 64'd0, "hist_bin2");
        read_rb(4'd15, 64'd1, "hist_bin7");
`else
        read_rb(4'd9, BAD, "no_hist_addr9");
        read_rb(4'd8, BAD, "no_hist_addr8");
`endif
        read_rb(4'd6, BAD, "bad_addr6");
        read_rb(4'd7, BAD, "bad_addr7");

        check64("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check64("lat_q_empty", 64'(lat_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/latency_monitor.md
Name: latency_monitor

Overview:
- Downstream consumer of the latency-test shift-register stage.
- Accepts its AXI stream output: 32-bit data plus 128-bit tuser, with the egress timestamp in tuser[63:32].
- On each packet's first beat, computes latency = current timer − stamped time and keeps last/min/max/sum/count statistics for host readback.
- Data and tuser pass through unchanged via a 2-entry skid buffer to the axi_wrapper s_axis port.

Parameters:
- TS_LSB, 32: bit offset of the 32-bit timestamp within tuser.
- SUM_WIDTH, 48: width of the latency accumulator.
- BIN_SHIFT, 4: histogram bin width as log2 cycles. Used only with the optional feature.

Ports:
- ce_clk  in  1  block clock.
- reset  in  1  reset, asynchronous, active-low; clock ce_clk.
- timer  in  64  free-running time counter, same timebase as the upstream stamp; bits [31:0] are used.
- clear  in  1  synchronous single-cycle strobe that clears the statistics.
- s_axis_tdata  in  32  input data.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  128  input tuser; {header[63:0], stamp[31:0], user[31:0]}.
- m_axis_tdata  out  32  output data.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  128  output tuser, unchanged from input.
- rb_addr  in  4  readback address.
- rb_data  out  64  registered readback data.
- sample_stb  out  1  one-cycle pulse when a latency sample is taken.

Behaviour:
- Reset (reset=0, asynchronous):
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tlast/tuser=0, rb_data=0, sample_stb=0.
  - sof=1, last_lat=0, min_lat=32'hFFFF_FFFF, max_lat=0, sum=0, count=0.
  - s_axis_tready goes to 1 on the first clock after reset deasserts.
- Handshake and pass-through:
  - A beat is accepted when s_axis_tvalid & s_axis_tready.
  - 2-entry skid buffer: s_axis_tready = registered "buffer not full".
  - Input-to-output latency is 1 cycle; sustains 1 beat/cycle while m_axis_tready=1.
  - Order is preserved; no beat is dropped or duplicated under any tready pattern.
  - Output holds stable while m_axis_tvalid & !m_axis_tready.
- SOF tracking:
  - sof cleared on an accepted non-last beat; set on an accepted tlast beat.
  - A single-beat packet (sof & tlast) is a valid SOF.
- Sampling, on an accepted beat with sof=1:
  - lat = timer[31:0] − s_axis_tuser[TS_LSB+31:TS_LSB], modulo 2^32 (wrap handled by unsigned subtraction).
  - Registered next cycle: last_lat=lat; min_lat=min(min_lat,lat); max_lat=max(max_lat,lat).
  - sum += lat, saturating at 2^SUM_WIDTH−1.
  - count += 1, saturating at 32'hFFFF_FFFF.
  - sample_stb pulses in the same cycle the statistics update.
- Clear:
  - Restores the reset values of the statistics only. The stream is unaffected and sof is not touched.
  - Clear and a sample in the same cycle: clear wins, and the sample becomes the first post-clear sample: min=max=last=lat, sum=lat, count=1.
- Readback: registered, 1-cycle latency.
  - 0: {32'd0, last_lat}
  - 1: {32'd0, min_lat}
  - 2: {32'd0, max_lat}
  - 3: zero-extended sum
  - 4: {32'd0, count}
  - 5: {min_lat, max_lat}
  - 8–15: histogram (optional feature)
  - All other addresses: 64'h0BADC0DE0BADC0DE.
  - A read in the same cycle as a statistics update returns the pre-update value.

Optional Feature:
- Macro LATMON_HIST_EN.
- When defined:
  - 8 histogram counters, 16 bits each, saturating.
  - bin = min(7, lat >> BIN_SHIFT); incremented on each sample.
  - Cleared by reset and by clear; same-cycle clear+sample leaves 1 in the sampled bin.
  - rb_addr 8+n reads {48'd0, bin[n]}.
- When undefined: no histogram logic; addresses 8–15 return 64'h0BADC0DE0BADC0DE.

Decomposition:
- Package latmon_pkg:
  - readback address constants RB_LAST=0, RB_MIN=1, RB_MAX=2, RB_SUM=3, RB_COUNT=4, RB_MINMAX=5, RB_HIST_BASE=8.
  - RB_BAD=64'h0BADC0DE0BADC0DE.
  - MIN_INIT=32'hFFFF_FFFF.
  - Histogram bin count 8.
- Sub-module latmon_skid: 2-entry AXI skid buffer, width 161 bits ({tlast, tuser, tdata}), same clock/reset.

Test Plan:
- Reset, then a 4-beat packet with stamp=100 and first-beat timer=130 -> output identical 1 cycle later; sample_stb once; rb 0/1/2/4 = 30/30/30/1.
- Three single-beat packets with latencies 5, 50, 20 -> min=5, max=50, sum=75, count=3; rb 5 = {32'd5, 32'd50}.
- Stamp=32'hFFFF_FFF0, timer[31:0]=32'h0000_0010 -> last_lat=32.
- Random m_axis_tready (50%) over 1000 beats with continuous s_axis_tvalid -> output sequence equals input; count = number of tlast beats; s_axis_tready never 0 while the buffer holds fewer than 2 entries.
- clear asserted in the same cycle as a sample with lat=7 -> min=max=last=7, sum=7, count=1. Reset asserted mid-packet -> m_axis_tvalid=0 immediately; next accepted beat is treated as SOF.
- With LATMON_HIST_EN and BIN_SHIFT=4: latencies 3, 17, 500 -> bin0=1, bin1=1, bin7=1. Without the macro: rb_addr 9 = 64'h0BADC0DE0BADC0DE.
